// File: rtl/gcd_stein_param.sv
// Multi-cycle binary (Stein) GCD of two unsigned WIDTH-bit operands.
// A start in IDLE runs CHECK/STRIP/NORM_A/REDUCE, then DONE pulses valid_o for one cycle.
module gcd_stein_param #(
  parameter int WIDTH = 32,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             coprime_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_STRIP  = 3'd2,
    S_NORM_A = 3'd3,
    S_REDUCE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] fin_val;
  logic             in_work;

  // Value delivered on entry to DONE: the surviving operand in CHECK,
  // or the odd common part re-scaled by the stripped power of two in REDUCE.
  assign fin_val = (state == S_REDUCE) ? (a << k)
                 : ((a == '0) ? b : a);

  assign in_work = (state == S_CHECK) || (state == S_STRIP) ||
                   (state == S_NORM_A) || (state == S_REDUCE);

  // NOTE: asynchronous reset lives in the sensitivity list; all state uses
  // non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      a         <= '0;
      b         <= '0;
      k         <= '0;
      result_o  <= '0;
      coprime_o <= 1'b0;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (in_work && abort_i) begin
        state  <= S_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              a      <= a_i;
              b      <= b_i;
              k      <= '0;
              state  <= S_CHECK;
              busy_o <= 1'b1;
            end
          end

          S_CHECK: begin
            if ((a == '0) || (b == '0)) begin
              result_o  <= fin_val;
              coprime_o <= (fin_val == WIDTH'(1));
              valid_o   <= 1'b1;
              busy_o    <= 1'b0;
              state     <= S_DONE;
            end else begin
              state <= S_STRIP;
            end
          end

          S_STRIP: begin
            if (!a[0] && !b[0]) begin
              a <= a >> 1;
              b <= b >> 1;
              k <= k + KW'(1);
            end else begin
              state <= S_NORM_A;
            end
          end

          S_NORM_A: begin
            if (!a[0]) a <= a >> 1;
            else       state <= S_REDUCE;
          end

          // a stays odd here, so a-b and b-a never wrap given the compare.
          S_REDUCE: begin
            if (!b[0]) begin
              b <= b >> 1;
            end else if (a == b) begin
              result_o  <= fin_val;
              coprime_o <= (fin_val == WIDTH'(1));
              valid_o   <= 1'b1;
              busy_o    <= 1'b0;
              state     <= S_DONE;
            end else if (a > b) begin
              a <= b;
              b <= a - b;
            end else begin
              b <= b - a;
            end
          end

          S_DONE: begin
            state <= S_IDLE;
          end

          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gcd_stein_param.sv
// Scoreboard bench for gcd_stein_param: a WIDTH=32 and a WIDTH=8 instance, directed
// vectors plus a short random set for the 8-bit instance, checked by per-instance monitors.
module tb_gcd_stein_param;

  localparam int W32     = 32;
  localparam int W8      = 8;
  localparam int BOUND32 = 6 * W32 + 4;
  localparam int BOUND8  = 6 * W8 + 4;

  typedef struct {
    logic [63:0] res;
    logic        cop;
    int          issue;
    int          exact;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic           rst32, start32, abort32, busy32, valid32, cop32;
  logic [W32-1:0] a32, b32, result32;
  logic           rst8, start8, abort8, busy8, valid8, cop8;
  logic [W8-1:0]  a8, b8, result8;

  exp_t q32[$];
  exp_t q8[$];

  gcd_stein_param #(.WIDTH(W32)) dut32 (
    .clk_i(clk), .rst_i(rst32), .start_i(start32), .abort_i(abort32),
    .a_i(a32), .b_i(b32), .busy_o(busy32), .valid_o(valid32),
    .result_o(result32), .coprime_o(cop32)
  );

  gcd_stein_param #(.WIDTH(W8)) dut8 (
    .clk_i(clk), .rst_i(rst8), .start_i(start8), .abort_i(abort8),
    .a_i(a8), .b_i(b8), .busy_o(busy8), .valid_o(valid8),
    .result_o(result8), .coprime_o(cop8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Euclid by remainder, deliberately a different algorithm from the DUT.
  function automatic int unsigned gcd_ref(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Latency counts the cycle that presents start as cycle 1, so the
  // a==0 / b==0 path shows valid in cycle 3.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (valid32) begin
      if (q32.size() == 0) begin
        check("unexpected_valid32", valid32, 1'b0);
      end else begin
        e   = q32.pop_front();
        lat = cyc - e.issue + 1;
        check("result32", result32, e.res);
        check("coprime32", cop32, e.cop);
        check("busy32_at_valid", busy32, 1'b0);
        if (e.exact != 0) check("latency32_exact", lat, e.exact);
        else              check("latency32_bound", (lat <= BOUND32), 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (valid8) begin
      if (q8.size() == 0) begin
        check("unexpected_valid8", valid8, 1'b0);
      end else begin
        e   = q8.pop_front();
        lat = cyc - e.issue + 1;
        check("result8", result8, e.res);
        check("coprime8", cop8, e.cop);
        if (e.exact != 0) check("latency8_exact", lat, e.exact);
        else              check("latency8_bound", (lat <= BOUND8), 1'b1);
      end
    end
  end

  task automatic drain32();
    int n = 0;
    while (q32.size() != 0 && n < BOUND32 + 8) begin
      @(negedge clk);
      n++;
    end
    if (q32.size() != 0) begin
      check("timeout32_pending", q32.size(), 0);
      q32.delete();
    end
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < BOUND8 + 8) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      check("timeout8_pending", q8.size(), 0);
      q8.delete();
    end
  endtask

  task automatic run32(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] res, input int exact);
    exp_t e;
    @(negedge clk);
    a32 = va; b32 = vb; start32 = 1'b1;
    e.res = 64'(res); e.cop = (res == 32'd1); e.issue = cyc; e.exact = exact;
    q32.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
    check("busy32_after_start", busy32, 1'b1);
    drain32();
  endtask

  task automatic run8(input logic [7:0] va, input logic [7:0] vb,
                      input logic [7:0] res, input int exact, input logic with_abort);
    exp_t e;
    @(negedge clk);
    a8 = va; b8 = vb; start8 = 1'b1; abort8 = with_abort;
    e.res = 64'(res); e.cop = (res == 8'd1); e.issue = cyc; e.exact = exact;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; abort8 = 1'b0;
    check("busy8_after_start", busy8, 1'b1);
    drain8();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] ra, rb;
    rst32 = 1'b1; start32 = 1'b0; abort32 = 1'b0; a32 = '0; b32 = '0;
    rst8  = 1'b1; start8  = 1'b0; abort8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy32", busy32, 1'b0);
    check("rst_valid32", valid32, 1'b0);
    check("rst_result32", result32, 0);
    check("rst_coprime32", cop32, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_result8", result8, 0);
    rst32 = 1'b0;
    rst8  = 1'b0;

    run32(32'd12, 32'd18, 32'd6, 0);
    run32(32'd0, 32'd35, 32'd35, 3);
    run32(32'd0, 32'd0, 32'd0, 3);
    run32(32'd35, 32'd0, 32'd35, 3);
    run32(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 0);
    run32(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0);
    run32(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 0);
    run32(32'd1071, 32'd462, 32'd21, 0);

    // Abort while STRIP is halving 48/180: no pulse, result stays 21.
    @(negedge clk);
    a32 = 32'd48; b32 = 32'd180; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    abort32 = 1'b1;
    @(negedge clk);
    abort32 = 1'b0;
    check("abort_busy32_low", busy32, 1'b0);
    repeat (BOUND32) @(negedge clk);
    check("abort_keeps_result32", result32, 32'd21);
    run32(32'd48, 32'd180, 32'd12, 0);

    // Start held high through DONE must not relaunch.
    @(negedge clk);
    a32 = 32'd0; b32 = 32'd35; start32 = 1'b1;
    e.res = 64'd35; e.cop = 1'b0; e.issue = cyc; e.exact = 3;
    q32.push_back(e);
    repeat (3) @(negedge clk);
    start32 = 1'b0;
    check("start_in_done_ignored32", busy32, 1'b0);
    repeat (10) @(negedge clk);
    drain32();

    // Reset while REDUCE is shifting b clears outputs at once.
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'h8000_0000; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    rst32 = 1'b1;
    #1;
    check("rst_mid_busy32", busy32, 1'b0);
    check("rst_mid_valid32", valid32, 1'b0);
    check("rst_mid_result32", result32, 0);
    check("rst_mid_coprime32", cop32, 1'b0);
    @(negedge clk);
    rst32 = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_no_valid32", valid32, 1'b0);
    run32(32'd12, 32'd18, 32'd6, 0);

    run8(8'd255, 8'd128, 8'd1, 0, 1'b0);
    run8(8'd128, 8'd128, 8'd128, 0, 1'b0);
    run8(8'd0, 8'd0, 8'd0, 3, 1'b0);
    run8(8'd255, 8'd0, 8'd255, 3, 1'b0);
    run8(8'd1, 8'd1, 8'd1, 0, 1'b0);
    run8(8'd200, 8'd150, 8'd50, 0, 1'b0);
    run8(8'd81, 8'd27, 8'd27, 0, 1'b0);
    run8(8'd17, 8'd13, 8'd1, 0, 1'b0);
    run8(8'd254, 8'd2, 8'd2, 0, 1'b0);
    run8(8'd96, 8'd64, 8'd32, 0, 1'b0);
    run8(8'd54, 8'd24, 8'd6, 0, 1'b1);

    for (int i = 0; i < 160; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run8(ra, rb, 8'(gcd_ref(32'(ra), 32'(rb))), 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
